// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Default geometry and a constant-foldable clog2.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR       = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, write-back clears, flush wipes.
// The population count is registered on the same edge as the vector.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(DEPTH),
  parameter int CW       = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iss_en_i,
  input  logic [AW-1:0]      iss_addr_i,
  input  logic [NWR-1:0]     wr_en_i,
  input  logic [NWR*AW-1:0]  wr_addr_i,
  input  logic               flush_i,
  output logic [DEPTH-1:0]   busy_o,
  output logic [CW-1:0]      cnt_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] set_v;
  logic [DEPTH-1:0] clr_v;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_en_i) set_v[iss_addr_i] = 1'b1;
    if (ZERO_REG != 0) set_v[0] = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en_i[k]) clr_v[wr_addr_i[k*AW +: AW]] = 1'b1;
    end
  end

  // Clear before set so an issue racing its own write-back stays busy.
  always_comb begin
    busy_d = (busy_q & ~clr_v) | set_v;
    if (flush_i) busy_d = '0;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d = cnt_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and a busy scoreboard.
// Read data and busy flags are combinational; all state is edge-updated.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(DEPTH),
  localparam int CW      = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_conflict,
  input  logic              flush,
  output logic [CW-1:0]     busy_cnt
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wa [NWR];
  logic [DW-1:0]    wd [NWR];
  logic [NWR-1:0]   wr_ok;
  logic [AW-1:0]    ra [NRD];
  logic [DW-1:0]    rv [NRD];
  logic [NRD-1:0]   hit;
  logic [DEPTH-1:0] busy;
  logic [CW-1:0]    cnt;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wa[k]    = wr_addr[k*AW +: AW];
      wd[k]    = wr_data[k*DW +: DW];
      wr_ok[k] = wr_en[k];
      if (ZERO_REG != 0 && wa[k] == '0) wr_ok[k] = 1'b0;
    end
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k]) mem_q[wa[k]] <= wd[k];
      end
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW),
    .CW       (CW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (reset),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .wr_en_i    (wr_ok),
    .wr_addr_i  (wr_addr),
    .flush_i    (flush),
    .busy_o     (busy),
    .cnt_o      (cnt)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit     = '0;
    for (int i = 0; i < NRD; i++) begin
      ra[i] = rd_addr[i*AW +: AW];
      rv[i] = mem_q[ra[i]];
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k] && wa[k] == ra[i]) begin
          rv[i]  = wd[k];
          hit[i] = 1'b1;
        end
      end
      if (ZERO_REG != 0 && ra[i] == '0) rv[i] = '0;
      // Bypass could leak input data while in reset; mask it.
      if (!reset) rv[i] = '0;
      rd_data[i*DW +: DW] = rv[i];
      rd_busy[i] = reset & busy[ra[i]] & ~hit[i];
    end
  end

  assign iss_conflict = reset & iss_en & busy[iss_addr];
  assign busy_cnt     = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_sb;

  localparam int K_RD0  = 0;
  localparam int K_RD1  = 1;
  localparam int K_BSY0 = 2;
  localparam int K_BSY1 = 3;
  localparam int K_CONF = 4;
  localparam int K_CNT  = 5;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_conflict;
  logic        flush;
  logic [5:0]  busy_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .DW       (32),
    .DEPTH    (32),
    .NRD      (2),
    .ZERO_REG (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .iss_en       (iss_en),
    .iss_addr     (iss_addr),
    .iss_conflict (iss_conflict),
    .flush        (flush),
    .busy_cnt     (busy_cnt)
  );

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RD0:   return rd_data[31:0];
      K_RD1:   return rd_data[63:32];
      K_BSY0:  return 32'(rd_busy[0]);
      K_BSY1:  return 32'(rd_busy[1]);
      K_CONF:  return 32'(iss_conflict);
      default: return 32'(busy_cnt);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e.kind);
      n_cmp++;
      if (a !== e.val) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
      end
    end
  end

  task automatic push(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic idle_in();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  initial begin
    reset   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    iss_addr = '0;
    idle_in();
    // Activity during reset must be masked and discarded.
    wr(0, 5'd6, 32'h0000_1234);
    iss(5'd6);
    rd(5'd6, 5'd6);
    #1;
    push(K_RD0, 32'h0, "rst_rd0");
    push(K_RD1, 32'h0, "rst_rd1_bypass_masked");
    push(K_BSY0, 32'h0, "rst_busy0");
    push(K_CONF, 32'h0, "rst_conf");
    push(K_CNT, 32'h0, "rst_cnt");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_in();

    cyc();
    rd(5'd6, 5'd6);
    push(K_RD0, 32'h0, "rst_write_dropped");
    push(K_BSY0, 32'h0, "rst_issue_dropped");
    push(K_CNT, 32'h0, "cnt_after_rst");

    cyc();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd5);
    push(K_RD0, 32'hDEAD_BEEF, "r5_bypass_p0");
    push(K_RD1, 32'hDEAD_BEEF, "r5_bypass_p1");
    cyc();
    rd(5'd5, 5'd5);
    push(K_RD0, 32'hDEAD_BEEF, "r5_array_p0");
    push(K_RD1, 32'hDEAD_BEEF, "r5_array_p1");

    cyc();
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rd(5'd7, 5'd5);
    push(K_RD0, 32'h22, "r7_bypass_p1_wins");
    cyc();
    wr(0, 5'd0, 32'hFFFF_FFFF);
    rd(5'd7, 5'd0);
    push(K_RD0, 32'h22, "r7_array_p1_wins");
    push(K_RD1, 32'h0, "r0_no_bypass");
    push(K_BSY1, 32'h0, "r0_busy");
    cyc();
    rd(5'd0, 5'd7);
    push(K_RD0, 32'h0, "r0_after_write");

    cyc();
    iss(5'd3);
    push(K_CNT, 32'd0, "cnt_before_iss3");
    push(K_CONF, 32'h0, "conf_iss3");
    cyc();
    iss(5'd4);
    push(K_CNT, 32'd1, "cnt_after_iss3");
    cyc();
    wr(0, 5'd3, 32'h33);
    rd(5'd3, 5'd4);
    push(K_CNT, 32'd2, "cnt_after_iss4");
    push(K_BSY0, 32'h0, "r3_busy_write_cycle");
    push(K_BSY1, 32'h1, "r4_busy");
    cyc();
    rd(5'd3, 5'd4);
    push(K_CNT, 32'd1, "cnt_after_wb3");
    push(K_BSY0, 32'h0, "r3_busy_after_wb");
    push(K_RD0, 32'h33, "r3_data");

    cyc();
    iss(5'd9);
    rd(5'd9, 5'd4);
    push(K_CONF, 32'h0, "conf_first_iss9");
    push(K_CNT, 32'd1, "cnt_pre_iss9");
    cyc();
    iss(5'd9);
    push(K_CONF, 32'h1, "conf_waw_iss9");
    push(K_CNT, 32'd2, "cnt_iss9");
    cyc();
    iss(5'd9);
    wr(0, 5'd9, 32'h99);
    push(K_CONF, 32'h1, "conf_iss_wb9");
    push(K_CNT, 32'd2, "cnt_waw_unchanged");
    push(K_BSY0, 32'h0, "r9_busy_masked_by_wb");
    cyc();
    push(K_BSY0, 32'h1, "r9_stays_busy");
    push(K_RD0, 32'h99, "r9_data");
    push(K_CNT, 32'd2, "cnt_issue_wins");

    for (int i = 0; i < 6; i++) begin
      cyc();
      iss(5'(11 + i));
      push(K_CNT, 32'(2 + i), "cnt_ramp");
    end
    cyc();
    flush = 1'b1;
    iss(5'd10);
    wr(1, 5'd12, 32'hAB);
    push(K_CNT, 32'd8, "cnt_eight_busy");
    push(K_CONF, 32'h0, "conf_flush_iss10");
    cyc();
    rd(5'd10, 5'd12);
    push(K_CNT, 32'd0, "cnt_after_flush");
    push(K_BSY0, 32'h0, "r10_not_busy");
    push(K_BSY1, 32'h0, "r12_not_busy");
    push(K_RD1, 32'hAB, "r12_write_in_flush");

    cyc();
    wr(0, 5'd2, 32'h55);
    iss(5'd20);
    cyc();
    iss(5'd21);
    cyc();
    iss(5'd22);
    cyc();
    rd(5'd2, 5'd20);
    push(K_RD0, 32'h55, "r2_before_rst");
    push(K_CNT, 32'd3, "cnt_before_rst");
    push(K_BSY1, 32'h1, "r20_busy");
    cyc();
    reset = 1'b0;
    wr(0, 5'd2, 32'h77);
    rd(5'd2, 5'd2);
    push(K_RD0, 32'h0, "r2_async_clear");
    push(K_RD1, 32'h0, "r2_bypass_in_rst");
    push(K_CNT, 32'd0, "cnt_async_clear");
    cyc();
    reset = 1'b1;
    cyc();
    rd(5'd2, 5'd20);
    push(K_RD0, 32'h0, "r2_after_rst");
    push(K_BSY1, 32'h0, "r20_after_rst");
    push(K_CNT, 32'd0, "cnt_after_rst2");

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
